// File: rtl/control_sequencer.sv
// Hardwired control unit for CPU_Datapath: sequences the T0..T6 fetch/decode/execute
// steps and decodes IR fields into register selects and the ALU operation.
module control_sequencer #(
    parameter int unsigned NREG    = 16,
    parameter logic [4:0]  OP_MUL  = 5'b01101,
    parameter logic [4:0]  OP_DIV  = 5'b01110,
    parameter logic [4:0]  OP_NOP  = 5'b11010,
    parameter logic [4:0]  OP_HALT = 5'b11111
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            run,
    input  logic            mem_ready,
    input  logic [31:0]     IR,
    output logic            PCout,
    output logic            MARin,
    output logic            IncPC,
    output logic            PCin,
    output logic            Read,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            ZLOout,
    output logic            ZHIout,
    output logic            ZLowSelect,
    output logic            HIin,
    output logic            Loin,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic [4:0]      ALUSelection,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state_q, state_d;
    logic   pcin_done_q, pcin_done_d;
    logic   illegal_q, illegal_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_md;
    logic       unused_ir_low;

    assign op            = IR[31:27];
    assign ra            = IR[26:23];
    assign rb            = IR[22:19];
    assign rc            = IR[18:15];
    assign unused_ir_low = ^IR[14:0];
    assign is_alu        = (op >= 5'd1) && (op <= 5'd12);
    assign is_md         = (op == OP_MUL) || (op == OP_DIV);

    function automatic logic [NREG-1:0] onehot(input logic [3:0] idx);
        logic [NREG-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= S_IDLE;
            pcin_done_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcin_done_q <= pcin_done_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pcin_done_d  = 1'b0;
        illegal_d    = illegal_q;
        PCout        = 1'b0;
        MARin        = 1'b0;
        IncPC        = 1'b0;
        PCin         = 1'b0;
        Read         = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        Zin          = 1'b0;
        ZLOout       = 1'b0;
        ZHIout       = 1'b0;
        ZLowSelect   = 1'b0;
        HIin         = 1'b0;
        Loin         = 1'b0;
        Rin          = '0;
        Rout         = '0;
        ALUSelection = '0;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                // PCin only on the first T1 cycle so memory stalls do not re-increment PC
                ZLOout = 1'b1; ZLowSelect = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin        = !pcin_done_q;
                pcin_done_d = 1'b1;
                if (mem_ready) state_d = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Rout = onehot(rb); Yin = 1'b1; state_d = S_T4;
                end else if (is_md) begin
                    Rout = onehot(ra); Yin = 1'b1; state_d = S_T4;
                end else if (op == OP_NOP) begin
                    state_d = run ? S_T0 : S_IDLE;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_T4: begin
                Rout         = is_md ? onehot(rb) : onehot(rc);
                ALUSelection = op;
                Zin          = 1'b1;
                state_d      = S_T5;
            end
            S_T5: begin
                ZLOout = 1'b1; ZLowSelect = 1'b1;
                if (is_md) begin
                    Loin = 1'b1; state_d = S_T6;
                end else begin
                    Rin = onehot(ra); state_d = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                ZHIout = 1'b1; HIin = 1'b1;
                state_d = run ? S_T0 : S_IDLE;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a step-level instruction model queues the
// expected strobe set per busy cycle; a monitor pops and compares each one.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] IR = '0;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin;
    logic ZLOout, ZHIout, ZLowSelect, HIin, Loin, busy, halted, illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALUSelection;

    control_sequencer #(.NREG(16)) dut (
        .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLOout(ZLOout), .ZHIout(ZHIout), .ZLowSelect(ZLowSelect), .HIin(HIin),
        .Loin(Loin), .Rin(Rin), .Rout(Rout), .ALUSelection(ALUSelection),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcout, marin, incpc, pcin, read, mdrin, mdrout, irin, yin, zin;
        logic zloout, zhiout, zlowsel, hiin, loin;
        logic [15:0] rin, rout;
        logic [4:0]  alu;
        logic busy, halted, illegal;
    } outs_t;

    outs_t  exp_q[$];
    outs_t  dval_q[$];
    string  dname_q[$];
    string  tmo_q[$];
    int     wq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic   done = 1'b0;

    function automatic outs_t sample();
        outs_t s;
        s = '{pcout:PCout, marin:MARin, incpc:IncPC, pcin:PCin, read:Read, mdrin:MDRin,
              mdrout:MDRout, irin:IRin, yin:Yin, zin:Zin, zloout:ZLOout, zhiout:ZHIout,
              zlowsel:ZLowSelect, hiin:HIin, loin:Loin, rin:Rin, rout:Rout,
              alu:ALUSelection, busy:busy, halted:halted, illegal:illegal};
        return s;
    endfunction

    function automatic outs_t step0();
        outs_t s;
        s = '0;
        s.busy = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        logic [31:0] v;
        v = $urandom;
        v[31:27] = 5'(op); v[26:23] = 4'(ra); v[22:19] = 4'(rb); v[18:15] = 4'(rc);
        return v;
    endfunction

    // Reference: the step list each instruction class produces, T1 stretched by w wait cycles
    task automatic push_instr(input logic [31:0] ir, input int w);
        outs_t s;
        int op, ra, rb, rc;
        op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        s = step0(); s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1; exp_q.push_back(s);
        for (int k = 0; k <= w; k++) begin
            s = step0(); s.zloout = 1; s.zlowsel = 1; s.read = 1; s.mdrin = 1;
            s.pcin = (k == 0);
            exp_q.push_back(s);
        end
        s = step0(); s.mdrout = 1; s.irin = 1; exp_q.push_back(s);
        if (op >= 1 && op <= 12) begin
            s = step0(); s.rout = 16'(1 << rb); s.yin = 1; exp_q.push_back(s);
            s = step0(); s.rout = 16'(1 << rc); s.alu = 5'(op); s.zin = 1; exp_q.push_back(s);
            s = step0(); s.zloout = 1; s.zlowsel = 1; s.rin = 16'(1 << ra); exp_q.push_back(s);
        end else if (op == 13 || op == 14) begin
            s = step0(); s.rout = 16'(1 << ra); s.yin = 1; exp_q.push_back(s);
            s = step0(); s.rout = 16'(1 << rb); s.alu = 5'(op); s.zin = 1; exp_q.push_back(s);
            s = step0(); s.zloout = 1; s.zlowsel = 1; s.loin = 1; exp_q.push_back(s);
            s = step0(); s.zhiout = 1; s.hiin = 1; exp_q.push_back(s);
        end else begin
            exp_q.push_back(step0());
        end
    endtask

    task automatic expect_now(input string name, input outs_t v);
        dname_q.push_back(name);
        dval_q.push_back(v);
    endtask

    task automatic wait_irin(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (IRin) return;
        end
        tmo_q.push_back(name);
    endtask

    task automatic wait_t4(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ALUSelection != 5'd0) return;
        end
        tmo_q.push_back(name);
    endtask

    task automatic wait_flag(input string name, input bit want_halt);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (want_halt ? halted : !busy) return;
        end
        tmo_q.push_back(name);
    endtask

    task automatic run_instr(input logic [31:0] ir, input int w);
        push_instr(ir, w);
        wq.push_back(w);
        run = 1'b1;
        wait_irin("irin_timeout");
        #1 IR = ir;
    endtask

    // Memory: holds mem_ready low for the requested number of cycles in each T1
    initial begin
        logic in_t1;
        int   cur;
        in_t1 = 1'b0; cur = 0;
        forever begin
            @(negedge clk);
            if (Read) begin
                if (!in_t1) cur = (wq.size() != 0) ? wq.pop_front() : 0;
                in_t1 = 1'b1;
                if (cur > 0) begin mem_ready = 1'b0; cur--; end
                else mem_ready = 1'b1;
            end else begin
                in_t1 = 1'b0;
                mem_ready = 1'b1;
            end
        end
    end

    // Monitor
    initial begin
        outs_t a, e;
        string nm;
        forever begin
            @(negedge clk);
            a = sample();
            while (tmo_q.size() != 0) begin
                nm = tmo_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL %s: bound expired waiting on DUT", nm);
            end
            if (dval_q.size() != 0) begin
                nm = dname_q.pop_front();
                e  = dval_q.pop_front();
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", nm, a, e);
                end
            end
            if (clr && busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_busy: got %h expected idle", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL step: got %h expected %h", a, e);
                    end
                end
            end
            if (done) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover_steps: got %0d pending expected 0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Driver
    initial begin
        outs_t idle, hlt, ill;
        logic [31:0] ir;
        int sel, op;
        idle = '0;
        hlt = '0; hlt.halted = 1'b1;
        ill = hlt; ill.illegal = 1'b1;

        repeat (2) @(negedge clk);
        #1 expect_now("reset_idle", idle);
        @(negedge clk); #1 clr = 1'b1;
        repeat (2) @(negedge clk);
        #1 expect_now("idle_run0", idle);
        @(negedge clk);

        run_instr(32'h28918000, 0);
        run_instr(mk_ir(13, 4, 5, $urandom_range(0, 15)), 3);
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            op  = (sel <= 6) ? $urandom_range(1, 12) : (sel == 7) ? 13 : (sel == 8) ? 14 : 26;
            run_instr(mk_ir(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                      $urandom_range(0, 3));
        end
        run_instr(mk_ir(1, 0, $urandom_range(0, 15), $urandom_range(0, 15)), $urandom_range(0, 3));
        wait_t4("t4_timeout");
        #1 run = 1'b0;
        wait_flag("idle_timeout", 1'b0);
        #1 expect_now("idle_after_run_drop", idle);
        @(negedge clk);

        run_instr(mk_ir(31, $urandom_range(0, 15), 0, 0), $urandom_range(0, 3));
        wait_flag("halt_timeout", 1'b1);
        #1 expect_now("halt", hlt);
        repeat (3) begin @(negedge clk); #1 run = ~run; end
        expect_now("halt_run_toggle", hlt);
        @(negedge clk); #1 clr = 1'b0; run = 1'b0;
        expect_now("clr_from_halt", idle);
        @(negedge clk); #1 clr = 1'b1;

        for (int k = 0; k < 2; k++) begin
            op = $urandom_range(15, 29);
            if (op >= 26) op++;
            if (k == 0) op = 0;
            @(negedge clk);
            run_instr(mk_ir(op, $urandom_range(0, 15), 0, 0), $urandom_range(0, 3));
            wait_flag("illegal_timeout", 1'b1);
            #1 expect_now("illegal_halt", ill);
            repeat (2) begin @(negedge clk); #1 run = ~run; end
            expect_now("illegal_sticky", ill);
            @(negedge clk); #1 clr = 1'b0; run = 1'b0;
            expect_now("illegal_cleared", idle);
            @(negedge clk); #1 clr = 1'b1;
        end

        @(negedge clk);
        run_instr(mk_ir(2, 7, 8, 9), 1);
        wait_t4("t4_reset_timeout");
        #1 clr = 1'b0; run = 1'b0;
        exp_q.delete();
        expect_now("reset_mid_t4", idle);
        @(negedge clk); #1 clr = 1'b1;
        repeat (3) @(negedge clk);
        #1 expect_now("idle_after_reset", idle);
        @(negedge clk);
        #1 done = 1'b1;
    end

endmodule
